dmem_bytelane: RTL
==================

// Module: dmem_bytelane
// PURPOSE
//  Parametrised MIPS data memory: successor of the fixed 64x32 word-only dmem.
//  - Byte/half/word loads and stores with per-byte write strobes.
//  - Sign/zero extension on loads, for lb/lbu/lh/lhu/lw/sb/sh/sw.
//  - Registered, configurable read latency behind a valid/ready request port.
//  - Misaligned and out-of-range accesses return an error flag.
//  - Sits between the MEM stage and the core bus.
// PARAMETERS
//  DEPTH     64   number of 32-bit words; power of 2, 16..4096
//  READ_LAT  1    cycles from request accept to rsp_valid; legal values 1 or 2
//  INIT_FILE ""   $readmemh image loaded at time 0; empty means no preload
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   block can accept; accept = req_valid & req_ready
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal (treated as error)
//  req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend; ignored on stores
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   one-cycle pulse per accepted request (loads and stores)
//  rsp_rdata     out  32  extended load data; 0 for stores and errors
//  rsp_err       out  1   misaligned, out-of-range or illegal size
// BEHAVIOUR
//  Reset and handshake
//  - Reset (async assert, sync release): req_ready=0, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, latency pipe flushed. RAM contents are not cleared.
//  - req_ready=1 from the first clk edge after rst_n deasserts. No backpressure:
//    one request per cycle, and the response is always taken.
//  - Reset mid-operation drops in-flight responses; no rsp_valid for them.
//    A store already committed to RAM stays committed.
//  Addressing and errors
//  - Word index = req_addr[AW+1:2], AW=$clog2(DEPTH).
//  - Out-of-range: any req_addr[31:AW+2] set -> err.
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 -> err.
//  - Error requests do not write RAM. They return rsp_err=1, rsp_rdata=0 after
//    READ_LAT cycles.
//  Stores
//  - Little-endian lanes: byte k = bits [8k+7:8k], k=addr[1:0].
//  - Strobes: byte 4'b0001<<k; half 4'b0011<<addr[1]*2; word 4'b1111.
//  - Write data is replicated across lanes. RAM is written on the accept edge.
//  Loads
//  - RAM is read on the accept edge.
//  - Lane select and extension are applied on the output register.
//  - rsp_valid is asserted READ_LAT cycles after accept.
//  - READ_LAT=2 adds one output pipeline register; no other change.
//  Ordering and timing
//  - Load after store to the same word returns the new data.
//    Back-to-back (store cycle n, load cycle n+1) is required to work.
//  - Responses return strictly in request order; throughput 1 per cycle.
//  - rsp_valid is driven with the same latency for stores and loads.
// STRUCTURE
//  - Package dmem_pkg holds SZ_BYTE/SZ_HALF/SZ_WORD localparams, the
//    strobe-generation function and the sign/zero-extend function.
//  - One sub-module, dmem_load_align (combinational): word, addr[1:0], size,
//    unsigned in; extended 32-bit result out.
//  - The RAM array is inferred in the top level.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid=1
//    -> req_ready=0, rsp_valid=0, rsp_rdata=0, RAM unchanged.
//  2 sw 0x8899AABC @0x10, then lw @0x10 next cycle
//    -> rsp_rdata=0x8899AABC, rsp_err=0, after READ_LAT.
//  3 After test 2:
//    lb @0x10 -> 0xFFFFFFBC
//    lbu @0x11 -> 0x000000AA
//    lh @0x12 -> 0xFFFF8899
//    lhu @0x12 -> 0x00008899
//  4 sb 0x55 @0x13, then lw @0x10 -> 0x5599AABC (other lanes untouched).
//  5 Error cases: sh @0x11, sw @0x12, sw @(DEPTH*4)
//    -> rsp_err=1, rsp_rdata=0, RAM unchanged on readback.
//  6 READ_LAT=2, 8 back-to-back loads, rst_n pulsed low after the 3rd
//    -> only pre-reset responses that had completed are seen, none after.
//    With no reset: responses arrive in order, one per cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access-size codes,
// store strobe and lane replication, and load sign/zero extension.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] strb;
      case (size)
         SZ_BYTE: strb = 4'b0001 << off;
         SZ_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Store data arrives right-justified; copy it onto every lane so the strobe picks it up.
   function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] rep;
      case (size)
         SZ_BYTE: rep = {4{wdata[7:0]}};
         SZ_HALF: rep = {2{wdata[15:0]}};
         default: rep = wdata;
      endcase
      return rep;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] lane, input logic [1:0] size,
                                          input logic is_unsigned);
      logic [31:0] ext;
      case (size)
         SZ_BYTE: ext = is_unsigned ? {24'h000000, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         SZ_HALF: ext = is_unsigned ? {16'h0000, lane[15:0]}   : {{16{lane[15]}}, lane[15:0]};
         SZ_WORD: ext = lane;
         default: ext = 32'h00000000;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load path: moves the addressed lane down to bit 0 and
// applies sign or zero extension for the access size.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [31:0] w_lane;

   assign w_lane = i_word >> {i_off, 3'b000};
   assign o_data = extend(w_lane, i_size, i_unsigned);

endmodule

// File: rtl/dmem_bytelane.sv
// MIPS data memory with byte/half/word access, per-byte write strobes,
// error detection and a 1- or 2-cycle registered response path.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int    DEPTH     = 64,
   parameter int    READ_LAT  = 1,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   r_mem [0:DEPTH-1];
   logic          r_ready;
   logic          r_v1;
   logic [31:0]   r_rd1;
   logic          r_err1;

   logic          w_accept;
   logic          w_oor;
   logic          w_misal;
   logic          w_err;
   logic          w_wr;
   logic          w_load_ok;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_strb;
   logic [31:0]   w_wdata;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_ld_data;

   assign w_accept  = req_valid & r_ready;
   assign w_idx     = req_addr[AW+1:2];
   assign w_oor     = |req_addr[31:AW+2];
   assign w_err     = w_oor | w_misal | (req_size == SZ_ILL);
   assign w_wr      = w_accept & req_we & ~w_err;
   assign w_load_ok = w_accept & ~req_we & ~w_err;
   assign w_strb    = gen_strobe(req_size, req_addr[1:0]);
   assign w_wdata   = replicate_wdata(req_size, req_wdata);
   assign w_rd_word = r_mem[w_idx];
   assign req_ready = r_ready;

   // Alignment check against the natural boundary of the access size
   always_comb begin
      w_misal = 1'b0;
      case (req_size)
         SZ_HALF: w_misal = req_addr[0];
         SZ_WORD: w_misal = |req_addr[1:0];
         default: w_misal = 1'b0;
      endcase
   end

   dmem_load_align u_align (
      .i_word     (w_rd_word),
      .i_off      (req_addr[1:0]),
      .i_size     (req_size),
      .i_unsigned (req_unsigned),
      .o_data     (w_ld_data)
   );

   // RAM byte-lane write on the accept edge; contents survive reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (w_wr && w_strb[k]) begin
            r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
         end
      end
   end

   // Ready rises on the first edge after reset release and stays up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
      end
   end

   // First response stage: read, align and extend captured on the accept edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_rd1  <= 32'h00000000;
         r_err1 <= 1'b0;
      end else begin
         r_v1   <= w_accept;
         r_err1 <= w_accept & w_err;
         r_rd1  <= w_load_ok ? w_ld_data : 32'h00000000;
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic        r_v2;
      logic [31:0] r_rd2;
      logic        r_err2;

      // Extra output stage for the two-cycle configuration
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v2   <= 1'b0;
            r_rd2  <= 32'h00000000;
            r_err2 <= 1'b0;
         end else begin
            r_v2   <= r_v1;
            r_rd2  <= r_rd1;
            r_err2 <= r_err1;
         end
      end

      assign rsp_valid = r_v2;
      assign rsp_rdata = r_rd2;
      assign rsp_err   = r_err2;
   end else begin : g_lat1
      assign rsp_valid = r_v1;
      assign rsp_rdata = r_rd1;
      assign rsp_err   = r_err1;
   end

endmodule
